// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the core writeback
//   path (always highest priority) and an external I/O requester. I/O writes
//   are buffered in a small circular FIFO and drained on cycles where the
//   core is not writing. If the core keeps the FIFO blocked for MAX_WAIT
//   consecutive cycles, the core is frozen for one cycle to force a drain.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   core_we/wa/wd         : core writeback request
//   io_valid/ready/wa/wd  : I/O write request handshake
//   rf_we/wa/wd           : register-file write port (we3/wa3/wd3)
//   core_stall            : registered; holds the core PC for one cycle
//   fifo_count            : number of buffered I/O writes
module regfile_write_arbiter #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     core_we,
   input  logic [3:0]               core_wa,
   input  logic [WIDTH-1:0]         core_wd,
   input  logic                     io_valid,
   output logic                     io_ready,
   input  logic [3:0]               io_wa,
   input  logic [WIDTH-1:0]         io_wd,
   output logic                     rf_we,
   output logic [3:0]               rf_wa,
   output logic [WIDTH-1:0]         rf_wd,
   output logic                     core_stall,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [7:0] MAX_WAIT_V = 8'(MAX_WAIT);

   typedef enum logic {RUN, STALL} state_t;

   state_t            state, state_next;
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;
   logic [7:0]        starve, starve_next;
   logic [3:0]        mem_wa [DEPTH];
   logic [WIDTH-1:0]  mem_wd [DEPTH];

   logic              empty;
   logic              enq;
   logic              deq;

   assign empty      = (count == '0);
   assign io_ready   = (count != CW'(DEPTH));
   assign fifo_count = count;
   assign core_stall = (state == STALL);

   // r0 is hard-wired to zero, so writes to it are acknowledged but dropped.
   assign enq = io_valid && io_ready && (io_wa != 4'd0);

   // Arbitration, starve counter and next state
   always_comb begin
      rf_we       = 1'b0;
      rf_wa       = core_wa;
      rf_wd       = core_wd;
      deq         = 1'b0;
      state_next  = state;
      starve_next = starve;

      if (state == RUN) begin
         if (core_we) begin
            rf_we = 1'b1;
            if (!empty) begin
               starve_next = starve + 8'd1;
               if (starve_next == MAX_WAIT_V) begin
                  state_next = STALL;
               end
            end else begin
               starve_next = 8'd0;
            end
         end else if (!empty) begin
            rf_we       = 1'b1;
            rf_wa       = mem_wa[rd_ptr];
            rf_wd       = mem_wd[rd_ptr];
            deq         = 1'b1;
            starve_next = 8'd0;
         end else begin
            starve_next = 8'd0;
         end
      end else begin
         // Forced drain: the core's request this cycle is ignored. STALL is
         // only entered with a non-empty FIFO; the guard is defensive.
         rf_we       = !empty;
         rf_wa       = mem_wa[rd_ptr];
         rf_wd       = mem_wd[rd_ptr];
         deq         = !empty;
         starve_next = 8'd0;
         state_next  = RUN;
      end

      if (reset) begin
         rf_we = 1'b0;
      end
   end

   // State, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         starve <= 8'd0;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         state  <= state_next;
         starve <= starve_next;
         if (enq) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (enq && !deq) begin
            count <= count + CW'(1);
         end else if (deq && !enq) begin
            count <= count - CW'(1);
         end
      end
   end

   // FIFO storage (data only, not reset)
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_wa[wr_ptr] <= io_wa;
         mem_wd[wr_ptr] <= io_wd;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (WIDTH=8, DEPTH=4, MAX_WAIT=8).
// Inputs change 1ns after each rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_regfile_write_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       core_we;
   logic [3:0] core_wa;
   logic [7:0] core_wd;
   logic       io_valid;
   logic       io_ready;
   logic [3:0] io_wa;
   logic [7:0] io_wd;
   logic       rf_we;
   logic [3:0] rf_wa;
   logic [7:0] rf_wd;
   logic       core_stall;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(.WIDTH(8), .DEPTH(4), .MAX_WAIT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .core_we    (core_we),
      .core_wa    (core_wa),
      .core_wd    (core_wd),
      .io_valid   (io_valid),
      .io_ready   (io_ready),
      .io_wa      (io_wa),
      .io_wd      (io_wd),
      .rf_we      (rf_we),
      .rf_wa      (rf_wa),
      .rf_wd      (rf_wd),
      .core_stall (core_stall),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; core_we = 1'b1; core_wa = 4'd1; core_wd = 8'h11;
      io_valid = 1'b1; io_wa = 4'd5; io_wd = 8'h55;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         @(negedge clk);
         checks++;
         if (rf_we !== 1'b0) begin
            errors++; $display("FAIL reset_rf_we cyc%0d got %b want 0", i, rf_we);
         end
      end
      next_cycle();
      reset = 1'b0; core_we = 1'b0; io_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++; $display("FAIL reset_count got %0d want 0", fifo_count);
      end
      checks++;
      if (core_stall !== 1'b0) begin
         errors++; $display("FAIL reset_stall got %b want 0", core_stall);
      end
      checks++;
      if (io_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", io_ready);
      end
      checks++;
      if (rf_we !== 1'b0) begin
         errors++; $display("FAIL reset_nowrite got %b want 0", rf_we);
      end
   endtask

   task automatic test_idle_drain();
      core_we = 1'b0; core_wa = 4'd1; core_wd = 8'h11;
      next_cycle();
      io_valid = 1'b1; io_wa = 4'd3; io_wd = 8'h5A;
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
         errors++; $display("FAIL idle_no_bypass got %b want 0", rf_we);
      end
      next_cycle();
      io_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd3, 8'h5A}) begin
         errors++; $display("FAIL idle_write got we=%b wa=%0d wd=%h want we=1 wa=3 wd=5a",
                            rf_we, rf_wa, rf_wd);
      end
      checks++;
      if (fifo_count !== 3'd1) begin
         errors++; $display("FAIL idle_count1 got %0d want 1", fifo_count);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
         errors++; $display("FAIL idle_empty got count=%0d we=%b want 0 0", fifo_count, rf_we);
      end
   endtask

   // Core writes r1 every cycle; r4..r7 fill the FIFO, r8 is refused.
   // Forced drains are expected in cycles 9, 18, 27 and 36.
   task automatic test_fill_and_forced_drain();
      int         k;
      logic       exp_stall;
      logic [2:0] exp_count;
      logic [3:0] exp_wa;
      logic [7:0] exp_wd;
      k = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         next_cycle();
         core_we = 1'b1; core_wa = 4'd1; core_wd = 8'h11;
         io_valid = (cyc < 5);
         io_wa = 4'(4 + cyc);
         io_wd = {io_wa, io_wa};
         exp_stall = (cyc == 9 || cyc == 18 || cyc == 27 || cyc == 36);
         if (cyc < 4)       exp_count = 3'(cyc);
         else if (cyc <= 9)  exp_count = 3'd4;
         else if (cyc <= 18) exp_count = 3'd3;
         else if (cyc <= 27) exp_count = 3'd2;
         else if (cyc <= 36) exp_count = 3'd1;
         else                exp_count = 3'd0;
         if (exp_stall) begin
            exp_wa = 4'(4 + k);
            exp_wd = {exp_wa, exp_wa};
         end else begin
            exp_wa = 4'd1;
            exp_wd = 8'h11;
         end
         @(negedge clk);
         checks++;
         if (core_stall !== exp_stall) begin
            errors++; $display("FAIL fill_stall cyc%0d got %b want %b", cyc, core_stall, exp_stall);
         end
         checks++;
         if ({rf_we, rf_wa, rf_wd} !== {1'b1, exp_wa, exp_wd}) begin
            errors++; $display("FAIL fill_rf cyc%0d got we=%b wa=%0d wd=%h want we=1 wa=%0d wd=%h",
                               cyc, rf_we, rf_wa, rf_wd, exp_wa, exp_wd);
         end
         checks++;
         if (fifo_count !== exp_count) begin
            errors++; $display("FAIL fill_count cyc%0d got %0d want %0d", cyc, fifo_count, exp_count);
         end
         checks++;
         if (io_ready !== (exp_count != 3'd4)) begin
            errors++; $display("FAIL fill_ready cyc%0d got %b want %b", cyc, io_ready, exp_count != 3'd4);
         end
         if (exp_stall) k++;
      end
   endtask

   task automatic test_r0_discard_wrap();
      logic [3:0] push_wa [11] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
      logic       push_v  [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      logic       cwe     [11] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      logic       exp_we  [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [3:0] exp_wa  [11] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1};
      logic [7:0] exp_wd  [11] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                   8'h66, 8'h77, 8'h11};
      for (int cyc = 0; cyc < 11; cyc++) begin
         next_cycle();
         core_we = cwe[cyc]; core_wa = 4'd1; core_wd = 8'h11;
         io_valid = push_v[cyc];
         io_wa = push_wa[cyc];
         io_wd = (push_wa[cyc] == 4'd0) ? 8'hFF : {push_wa[cyc], push_wa[cyc]};
         @(negedge clk);
         checks++;
         if (rf_we !== exp_we[cyc] ||
             (exp_we[cyc] && (rf_wa !== exp_wa[cyc] || rf_wd !== exp_wd[cyc]))) begin
            errors++; $display("FAIL wrap_rf cyc%0d got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                               cyc, rf_we, rf_wa, rf_wd, exp_we[cyc], exp_wa[cyc], exp_wd[cyc]);
         end
      end
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++; $display("FAIL wrap_count got %0d want 0", fifo_count);
      end
   endtask

   // Three entries with a busy core: the forced drain lands in cycle 9,
   // where reset is asserted instead.
   task automatic test_reset_mid_op();
      for (int cyc = 0; cyc < 9; cyc++) begin
         next_cycle();
         core_we = 1'b1; core_wa = 4'd1; core_wd = 8'h11;
         io_valid = (cyc < 3);
         io_wa = 4'(9 + cyc);
         io_wd = 8'hA0 + 8'(cyc);
      end
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd3 || core_stall !== 1'b0) begin
         errors++; $display("FAIL midrst_pre got count=%0d stall=%b want 3 0", fifo_count, core_stall);
      end
      next_cycle();
      io_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (core_stall !== 1'b1) begin
         errors++; $display("FAIL midrst_in_stall got %b want 1", core_stall);
      end
      checks++;
      if (rf_we !== 1'b0) begin
         errors++; $display("FAIL midrst_we got %b want 0", rf_we);
      end
      next_cycle();
      reset = 1'b0; core_we = 1'b0;
      @(negedge clk);
      checks++;
      if (core_stall !== 1'b0 || fifo_count !== 3'd0 || io_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_after got stall=%b count=%0d ready=%b want 0 0 1",
                            core_stall, fifo_count, io_ready);
      end
      for (int cyc = 0; cyc < 4; cyc++) begin
         next_cycle();
         @(negedge clk);
         checks++;
         if (rf_we !== 1'b0) begin
            errors++; $display("FAIL midrst_stale cyc%0d got we=%b wa=%0d want we=0", cyc, rf_we, rf_wa);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_drain();
      test_fill_and_forced_drain();
      test_r0_discard_wrap();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
